uart_rx_frame_ctrl: RTL and testbench

//  Frame controller downstream of the UART byte receiver. Consumes uart_rx_done/uart_rx_data,

---
 rtl/uart_rx_frame_ctrl_pkg.sv | 24 ++
 rtl/uart_rx_frame_ctrl_gap_timer.sv | 31 +++
 rtl/uart_rx_frame_ctrl.sv | 150 +++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types and constants for the UART receive frame controller.
// Covers FSM state encodings, error cause codes and the default header bytes.
package uart_rx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_LEN = 2'd0,
    ERR_CHK = 2'd1,
    ERR_TMO = 2'd2,
    ERR_OVR = 2'd3
  } err_t;

  localparam logic [7:0] HDR0_DEF = 8'hA5;
  localparam logic [7:0] HDR1_DEF = 8'h5A;

endpackage

// File: rtl/uart_rx_frame_ctrl_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles since the last clear.
// It pulses expire when the count reaches TO_CLKS-1.
module uart_rx_gap_timer #(
  parameter int TO_CLKS = 4340
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TO_CLKS > 1) ? $clog2(TO_CLKS) : 1;

  logic [CW-1:0] cnt;

  // A byte arriving in the expiry cycle wins, so clr masks the pulse.
  assign expire = en && !clr && (cnt == CW'(TO_CLKS - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || !en || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller after the UART byte receiver.
// It hunts the header, buffers the payload, verifies the checksum and drains the payload on a valid/ready stream.
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter int         CLK_FRE      = 50_000_000,
  parameter int         BPS          = 230400,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] HDR0         = HDR0_DEF,
  parameter logic [7:0] HDR1         = HDR1_DEF,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rx_done,
  input  logic [7:0] uart_rx_data,
  output logic [7:0] pld_data,
  output logic       pld_valid,
  input  logic       pld_ready,
  output logic       pld_last,
  output logic [7:0] frm_len,
  output logic       frm_ok,
  output logic       frm_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int TO_CLKS = CLK_FRE / BPS * TIMEOUT_BITS;
  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t           state, state_nxt;
  logic [7:0]       len, sum, len_m1;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [7:0]       pld_buf [MAX_LEN];
  logic             gap_en, gap_expire, xfer;
  logic             len_load, data_wr, ok_set, err_set;
  err_t             err_sel;
  logic [1:0]       err_q;

  assign len_m1    = len - 8'd1;
  assign pld_valid = (state == S_DRAIN);
  assign pld_data  = pld_valid ? pld_buf[rd_idx] : '0;
  assign pld_last  = pld_valid && (8'(rd_idx) == len_m1);
  assign frm_len   = pld_valid ? len : '0;
  assign busy      = (state != S_IDLE);
  assign err_code  = err_q;
  assign xfer      = pld_valid && pld_ready;
  assign gap_en    = state inside {S_HDR1, S_LEN, S_DATA, S_CHK};

  uart_rx_gap_timer #(.TO_CLKS(TO_CLKS)) u_gap_timer (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clr    (uart_rx_done),
    .en     (gap_en),
    .expire (gap_expire)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    len_load  = 1'b0;
    data_wr   = 1'b0;
    ok_set    = 1'b0;
    err_set   = 1'b0;
    err_sel   = ERR_LEN;
    if (gap_expire) begin
      state_nxt = S_IDLE;
      err_set   = 1'b1;
      err_sel   = ERR_TMO;
    end else begin
      case (state)
        S_IDLE: if (uart_rx_done && uart_rx_data == HDR0) state_nxt = S_HDR1;
        S_HDR1: if (uart_rx_done) begin
          if (uart_rx_data == HDR1)      state_nxt = S_LEN;
          else if (uart_rx_data != HDR0) state_nxt = S_IDLE;
        end
        S_LEN: if (uart_rx_done) begin
          if (uart_rx_data == 8'd0 || uart_rx_data > 8'(MAX_LEN)) begin
            state_nxt = S_IDLE;
            err_set   = 1'b1;
            err_sel   = ERR_LEN;
          end else begin
            len_load  = 1'b1;
            state_nxt = S_DATA;
          end
        end
        S_DATA: if (uart_rx_done) begin
          data_wr = 1'b1;
          if (8'(wr_idx) == len_m1) state_nxt = S_CHK;
        end
        S_CHK: if (uart_rx_done) begin
          if (uart_rx_data == sum) begin
            ok_set    = 1'b1;
            state_nxt = S_DRAIN;
          end else begin
            err_set   = 1'b1;
            err_sel   = ERR_CHK;
            state_nxt = S_IDLE;
          end
        end
        S_DRAIN: begin
          // Bytes arriving while draining are dropped; the drain itself carries on.
          if (uart_rx_done) begin
            err_set = 1'b1;
            err_sel = ERR_OVR;
          end
          if (xfer && pld_last) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      len     <= '0;
      sum     <= '0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      frm_ok  <= 1'b0;
      frm_err <= 1'b0;
      err_q   <= '0;
    end else begin
      frm_ok  <= ok_set;
      frm_err <= err_set;
      if (err_set) err_q <= err_sel;
      if (len_load) begin
        len    <= uart_rx_data;
        sum    <= uart_rx_data;
        wr_idx <= '0;
      end else if (data_wr) begin
        sum    <= sum + uart_rx_data;
        wr_idx <= wr_idx + 1'b1;
      end
      if (ok_set)    rd_idx <= '0;
      else if (xfer) rd_idx <= rd_idx + 1'b1;
    end
  end

  // NOTE: the payload buffer has no reset; its contents are only read after being written.
  always_ff @(posedge sys_clk) begin
    if (data_wr) pld_buf[wr_idx] <= uart_rx_data;
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl.
// A table of byte streams is applied, and a scoreboard queue checks the drained payload.
module tb_uart_rx_frame_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       uart_rx_done = 1'b0;
  logic [7:0] uart_rx_data = '0;
  logic [7:0] pld_data;
  logic       pld_valid;
  logic       pld_ready = 1'b1;
  logic       pld_last;
  logic [7:0] frm_len;
  logic       frm_ok;
  logic       frm_err;
  logic [1:0] err_code;
  logic       busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ok_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] len;
  } pld_t;

  typedef struct {
    int           n;
    logic [159:0] raw;
    logic         ok;
    int           len;
    logic         err;
    logic [1:0]   code;
  } vec_t;

  pld_t exp_q[$];
  vec_t vecs[7];

  uart_rx_frame_ctrl #(
    .CLK_FRE(50_000_000), .BPS(230400), .MAX_LEN(16),
    .HDR0(8'hA5), .HDR1(8'h5A), .TIMEOUT_BITS(20)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .uart_rx_done(uart_rx_done), .uart_rx_data(uart_rx_data),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
    .pld_last(pld_last), .frm_len(frm_len), .frm_ok(frm_ok),
    .frm_err(frm_err), .err_code(err_code), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // The monitor counts the status pulses and pops the scoreboard on every transfer.
  always @(negedge sys_clk) begin
    if (frm_ok) ok_cnt++;
    if (frm_err) err_cnt++;
    if (frm_ok || frm_err) check("ok_err_exclusive", {31'd0, frm_ok && frm_err}, 32'd0);
    if (pld_valid && pld_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_payload", {24'd0, pld_data}, 32'hFFFF_FFFF);
      end else begin
        pld_t e;
        e = exp_q.pop_front();
        check("pld_data", {24'd0, pld_data}, {24'd0, e.data});
        check("pld_last", {31'd0, pld_last}, {31'd0, e.last});
        check("frm_len", {24'd0, frm_len}, {24'd0, e.len});
      end
    end
  end

  function automatic vec_t mk(input int n, input logic [159:0] raw, input logic ok,
                              input int len, input logic err, input logic [1:0] code);
    vec_t v;
    v.n = n; v.raw = raw; v.ok = ok; v.len = len; v.err = err; v.code = code;
    return v;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx_done = 1'b1;
    uart_rx_data = b;
    @(posedge sys_clk);
    #1;
    uart_rx_done = 1'b0;
    uart_rx_data = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (busy && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    wait_cycles(2);
  endtask

  task automatic push_pld(input logic [7:0] d, input logic last, input logic [7:0] len);
    pld_t e;
    e.data = d; e.last = last; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic apply(input int idx);
    vec_t v;
    int ok0, err0;
    v = vecs[idx];
    ok0 = ok_cnt;
    err0 = err_cnt;
    if (v.ok) begin
      for (int k = v.n - 1 - v.len; k <= v.n - 2; k++)
        push_pld(v.raw[8*(v.n-1-k) +: 8], k == v.n - 2, 8'(v.len));
    end
    for (int k = 0; k < v.n; k++) begin
      send_byte(v.raw[8*(v.n-1-k) +: 8]);
      wait_cycles(2);
    end
    wait_idle(200);
    check($sformatf("v%0d_ok_pulses", idx), ok_cnt - ok0, {31'd0, v.ok});
    check($sformatf("v%0d_err_pulses", idx), err_cnt - err0, {31'd0, v.err});
    if (v.err) check($sformatf("v%0d_err_code", idx), {30'd0, err_code}, {30'd0, v.code});
    check($sformatf("v%0d_queue_empty", idx), exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ok0, err0, n, bad;

    vecs[0] = mk(7, 160'({8'hA5, 8'h5A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}), 1'b1, 3, 1'b0, 2'd0);
    vecs[1] = mk(7, 160'({8'hA5, 8'h5A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68}), 1'b0, 0, 1'b1, 2'd1);
    vecs[2] = mk(3, 160'({8'hA5, 8'h5A, 8'h00}), 1'b0, 0, 1'b1, 2'd0);
    vecs[3] = mk(3, 160'({8'hA5, 8'h5A, 8'h11}), 1'b0, 0, 1'b1, 2'd0);
    vecs[4] = mk(7, 160'({8'hFF, 8'hA5, 8'hA5, 8'h5A, 8'h01, 8'h7E, 8'h7F}), 1'b1, 1, 1'b0, 2'd0);
    vecs[5] = mk(20, 160'({8'hA5, 8'h5A, 8'h10,
                           8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                           8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h88}),
                 1'b1, 16, 1'b0, 2'd0);
    vecs[6] = mk(8, 160'({8'hA5, 8'h33, 8'hA5, 8'h5A, 8'h02, 8'h01, 8'h02, 8'h05}), 1'b1, 2, 1'b0, 2'd0);

    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pld_valid", {31'd0, pld_valid}, 32'd0);
    check("rst_pld_data", {24'd0, pld_data}, 32'd0);
    check("rst_flags", {29'd0, frm_ok, frm_err, pld_last}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);

    for (int i = 0; i < 7; i++) apply(i);

    // Silence after a partial frame times out exactly once, after 4340 clocks.
    err0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h02); send_byte(8'h10);
    n = 0;
    while (n < 5000) begin
      @(posedge sys_clk);
      n++;
      @(negedge sys_clk);
      if (frm_err) break;
    end
    check("tmo_latency", n, 4340);
    check("tmo_err_code", {30'd0, err_code}, 32'd2);
    wait_cycles(100);
    check("tmo_single_pulse", err_cnt - err0, 1);
    check("tmo_idle", {31'd0, busy}, 32'd0);
    apply(0);

    // A byte landing in the expiry cycle wins over the timeout.
    ok0 = ok_cnt;
    err0 = err_cnt;
    push_pld(8'h10, 1'b0, 8'd2);
    push_pld(8'h20, 1'b1, 8'd2);
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h02); send_byte(8'h10);
    wait_cycles(4339);
    send_byte(8'h20);
    wait_cycles(2);
    send_byte(8'h32);
    wait_idle(200);
    check("tmo_edge_ok", ok_cnt - ok0, 1);
    check("tmo_edge_no_err", err_cnt - err0, 0);

    // A stalled sink holds the first byte, and an overrun byte during the stall is dropped.
    pld_ready = 1'b0;
    ok0 = ok_cnt;
    push_pld(8'hAB, 1'b0, 8'd2);
    push_pld(8'hCD, 1'b1, 8'd2);
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h02);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h7A);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (!(pld_valid && pld_data == 8'hAB)) bad++;
    end
    check("stall_hold", bad, 0);
    #1;
    err0 = err_cnt;
    send_byte(8'h99);
    wait_cycles(2);
    check("ovr_err_pulse", err_cnt - err0, 1);
    check("ovr_err_code", {30'd0, err_code}, 32'd3);
    pld_ready = 1'b1;
    wait_idle(200);
    check("ovr_drain_ok", ok_cnt - ok0, 1);
    check("ovr_queue_empty", exp_q.size(), 0);

    // Reset in DATA aborts the frame immediately, without raising an error.
    err0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h03); send_byte(8'h11);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_err_code", {30'd0, err_code}, 32'd0);
    check("mid_rst_outputs", {22'd0, pld_valid, frm_ok, frm_err, pld_last, pld_data}, 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    wait_cycles(5);
    check("rst_no_err", err_cnt - err0, 0);
    apply(0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
